// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game controller: growing rounds over an external sequence ROM,
// with per-move timeout, selectable game length and Moore status outputs.
module jogo_sequencia_param #(
    parameter int N_BOTOES = 4,
    parameter int END_BITS = 4,
    parameter int TIMEOUT  = 5000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                nivel,
    input  logic [N_BOTOES-1:0] chaves,
    output logic [END_BITS-1:0] mem_addr,
    input  logic [N_BOTOES-1:0] mem_data,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic [N_BOTOES-1:0] leds,
    output logic [END_BITS-1:0] db_rodada,
    output logic [END_BITS-1:0] db_contagem,
    output logic [3:0]          db_estado,
    output logic                db_igual,
    output logic                db_tem_jogada
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]       TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [END_BITS-1:0] LAST_CURTO = END_BITS'((1 << (END_BITS - 1)) - 1);
    localparam logic [END_BITS-1:0] LAST_LONGO = '1;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARA        = 4'h5,
        PROXIMO        = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTO     = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERRO       = 4'hE
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [END_BITS-1:0] rodada_q, rodada_d;
    logic [END_BITS-1:0] contagem_q, contagem_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [N_BOTOES-1:0] jogada_q, jogada_d;
    logic                nivel_q, nivel_d;
    logic                prev_any_q;

    logic                tem_jogada;
    logic                igual;
    logic [END_BITS-1:0] ultimo;

    // A held key produces a single pulse: only the rising edge of "any key" counts.
    assign tem_jogada = (|chaves) & ~prev_any_q;
    assign igual      = (jogada_q == mem_data);
    assign ultimo     = nivel_q ? LAST_LONGO : LAST_CURTO;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            rodada_q   <= '0;
            contagem_q <= '0;
            timer_q    <= '0;
            jogada_q   <= '0;
            nivel_q    <= 1'b0;
            prev_any_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            rodada_q   <= rodada_d;
            contagem_q <= contagem_d;
            timer_q    <= timer_d;
            jogada_q   <= jogada_d;
            nivel_q    <= nivel_d;
            prev_any_q <= |chaves;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        rodada_d   = rodada_q;
        contagem_d = contagem_q;
        timer_d    = timer_q;
        jogada_d   = jogada_q;
        nivel_d    = nivel_q;
        case (estado_q)
            INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                rodada_d   = '0;
                contagem_d = '0;
                jogada_d   = '0;
                timer_d    = '0;
                nivel_d    = nivel;
                estado_d   = INICIA_RODADA;
            end
            INICIA_RODADA: begin
                contagem_d = '0;
                timer_d    = '0;
                estado_d   = ESPERA;
            end
            ESPERA: begin
                if (tem_jogada) begin
                    timer_d  = '0;
                    estado_d = REGISTRA;
                end else if (timer_q == TIMER_LAST) begin
                    estado_d = FIM_TIMEOUT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            REGISTRA: begin
                jogada_d = chaves;
                estado_d = COMPARA;
            end
            COMPARA: begin
                if (!igual)                      estado_d = FIM_ERRO;
                else if (contagem_q != rodada_q) estado_d = PROXIMO;
                else if (rodada_q == ultimo)     estado_d = FIM_ACERTO;
                else                             estado_d = PROXIMA_RODADA;
            end
            PROXIMO: begin
                contagem_d = contagem_q + END_BITS'(1);
                timer_d    = '0;
                estado_d   = ESPERA;
            end
            PROXIMA_RODADA: begin
                rodada_d = rodada_q + END_BITS'(1);
                estado_d = INICIA_RODADA;
            end
            default: estado_d = INICIAL;
        endcase
    end

    assign mem_addr      = contagem_q;
    assign pronto        = (estado_q == FIM_ACERTO) || (estado_q == FIM_ERRO) || (estado_q == FIM_TIMEOUT);
    assign acertou       = (estado_q == FIM_ACERTO);
    assign errou         = (estado_q == FIM_ERRO) || (estado_q == FIM_TIMEOUT);
    assign timeout       = (estado_q == FIM_TIMEOUT);
    assign leds          = jogada_q;
    assign db_rodada     = rodada_q;
    assign db_contagem   = contagem_q;
    assign db_estado     = estado_q;
    assign db_igual      = igual;
    assign db_tem_jogada = tem_jogada;

endmodule
